// File: rtl/riscv_trace_collector.sv
// Converts register-writeback and memory trace strobes into sequence-numbered records in a dual-push FIFO.
// Latency: 1 cycle from capture to trace_valid when the FIFO is empty; first-word-fall-through head.
// Backpressure: never stalls the core; events that find no room are dropped and counted.
module riscv_trace_collector #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trace_en,
    input  logic                       reg_write_sig,
    input  logic [4:0]                 reg_num,
    input  logic [DATA_W-1:0]          reg_data,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W-1:0]          rd_data,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [1:0]                 trace_kind,
    output logic [ADDR_W-1:0]          trace_tag,
    output logic [DATA_W-1:0]          trace_data,
    output logic [15:0]                trace_seq,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic                       proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] tag;
        logic [DATA_W-1:0] data;
        logic [15:0]       seq;
    } rec_t;

    rec_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   seq_cnt;

    logic          reg_ev, mem_ev, push_reg, push_mem, pop;
    logic [CW-1:0] free;
    logic [1:0]    n_ev, n_push, n_drop;
    logic [8:0]    drop_sum;
    logic [PW-1:0] mem_idx;
    rec_t          reg_rec, mem_rec, head;

    always_comb begin
        reg_ev   = trace_en && reg_write_sig && (reg_num != 5'd0);
        mem_ev   = trace_en && (wr || rd);
        // Room is judged on start-of-cycle occupancy; a concurrent pop frees nothing.
        free     = CW'(DEPTH) - count;
        push_reg = reg_ev && (free != '0);
        push_mem = mem_ev && (reg_ev ? (free >= CW'(2)) : (free != '0));
        n_ev     = 2'(reg_ev) + 2'(mem_ev);
        n_push   = 2'(push_reg) + 2'(push_mem);
        n_drop   = n_ev - n_push;
        drop_sum = {1'b0, drop_count} + 9'(n_drop);
        pop      = trace_valid && trace_ready;
        mem_idx  = wr_ptr + PW'(push_reg);

        reg_rec.kind = 2'b00;
        reg_rec.tag  = ADDR_W'(reg_num);
        reg_rec.data = reg_data;
        reg_rec.seq  = seq_cnt;

        mem_rec.kind = wr ? 2'b10 : 2'b01;
        mem_rec.tag  = addr;
        mem_rec.data = wr ? wr_data : rd_data;
        mem_rec.seq  = seq_cnt + 16'(reg_ev);
    end

    always_ff @(posedge clk) begin
        if (push_reg) mem[wr_ptr]  <= reg_rec;
        if (push_mem) mem[mem_idx] <= mem_rec;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq_cnt    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(n_push);
            rd_ptr  <= rd_ptr + PW'(pop);
            count   <= count + CW'(n_push) - CW'(pop);
            seq_cnt <= seq_cnt + 16'(n_ev);
            if (n_drop != 2'd0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
            if (trace_en && wr && rd) proto_err <= 1'b1;
        end
    end

    // Head fields are forced to zero while empty so reset leaves them reading 0.
    always_comb begin
        trace_valid = (count != '0);
        head        = trace_valid ? mem[rd_ptr] : '0;
        trace_kind  = head.kind;
        trace_tag   = head.tag;
        trace_data  = head.data;
        trace_seq   = head.seq;
        fifo_count  = count;
    end

endmodule

// File: tb/tb_riscv_trace_collector.sv
// Directed bench for riscv_trace_collector with a 4-entry FIFO; expected values are hand-computed.
// Inputs change 1 ns after the rising edge and outputs are sampled at that same point.
module tb_riscv_trace_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en;
    logic        reg_write_sig;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        wr, rd;
    logic [8:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [1:0]  trace_kind;
    logic [8:0]  trace_tag;
    logic [31:0] trace_data;
    logic [15:0] trace_seq;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        proto_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    riscv_trace_collector #(.DATA_W(32), .DEPTH(4), .ADDR_W(9)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en),
        .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_kind(trace_kind), .trace_tag(trace_tag), .trace_data(trace_data),
        .trace_seq(trace_seq), .fifo_count(fifo_count), .overflow(overflow),
        .drop_count(drop_count), .proto_err(proto_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trace_en      = 1'b1;
        reg_write_sig = 1'b0;
        reg_num       = '0;
        reg_data      = '0;
        wr            = 1'b0;
        rd            = 1'b0;
        addr          = '0;
        wr_data       = '0;
        rd_data       = '0;
    endtask

    task automatic set_reg(input logic [4:0] n, input logic [31:0] d);
        reg_write_sig = 1'b1;
        reg_num       = n;
        reg_data      = d;
    endtask

    task automatic set_wr(input logic [8:0] a, input logic [31:0] d);
        wr      = 1'b1;
        addr    = a;
        wr_data = d;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    task automatic check_head(input string tag, input logic [1:0] k, input logic [8:0] t,
                              input logic [31:0] d, input logic [15:0] s);
        check({tag, "_valid"}, 32'(trace_valid), 32'd1);
        check({tag, "_kind"},  32'(trace_kind),  32'(k));
        check({tag, "_tag"},   32'(trace_tag),   32'(t));
        check({tag, "_data"},  trace_data,       d);
        check({tag, "_seq"},   32'(trace_seq),   32'(s));
    endtask

    initial begin
        idle();
        reset       = 1'b0;
        trace_ready = 1'b0;
        #1;

        // Reset held two cycles with random activity on every capture input.
        for (int i = 0; i < 2; i++) begin
            reg_write_sig = 1'b1;
            reg_num       = 5'($urandom_range(1, 31));
            reg_data      = $urandom;
            wr            = 1'($urandom);
            rd            = 1'b1;
            addr          = 9'($urandom);
            wr_data       = $urandom;
            rd_data       = $urandom;
            trace_ready   = 1'($urandom);
            cyc();
        end
        check("rst_valid", 32'(trace_valid), 32'd0);
        check("rst_count", 32'(fifo_count),  32'd0);
        check("rst_drop",  32'(drop_count),  32'd0);
        check("rst_ovf",   32'(overflow),    32'd0);
        check("rst_perr",  32'(proto_err),   32'd0);
        check("rst_seq",   32'(trace_seq),   32'd0);
        idle();
        trace_ready = 1'b0;
        reset       = 1'b1;

        // Single register write, popped on the edge after it appears.
        trace_ready = 1'b1;
        set_reg(5'd5, 32'hDEADBEEF);
        cyc();
        idle();
        check_head("single", 2'b00, 9'h005, 32'hDEADBEEF, 16'd0);
        cyc();
        check("single_empty", 32'(trace_valid), 32'd0);

        // Register and memory write in one cycle.
        do_reset();
        trace_ready = 1'b0;
        set_reg(5'd3, 32'd7);
        set_wr(9'h010, 32'h55);
        cyc();
        idle();
        check("dual_count", 32'(fifo_count), 32'd2);
        check_head("dual0", 2'b00, 9'h003, 32'd7, 16'd0);
        trace_ready = 1'b1;
        cyc();
        check("dual_count1", 32'(fifo_count), 32'd1);
        check_head("dual1", 2'b10, 9'h010, 32'h55, 16'd1);
        cyc();
        check("dual_empty", 32'(trace_valid), 32'd0);

        // Filtering: x0 writes and disabled capture produce nothing; wr+rd flags an error.
        do_reset();
        trace_ready = 1'b0;
        set_reg(5'd0, 32'h1111);
        cyc();
        idle();
        check("x0_valid", 32'(trace_valid), 32'd0);
        trace_en = 1'b0;
        set_reg(5'd7, 32'h2222);
        set_wr(9'h011, 32'h3333);
        cyc();
        idle();
        check("dis_valid", 32'(trace_valid), 32'd0);
        set_wr(9'h020, 32'hAA);
        rd      = 1'b1;
        rd_data = 32'hBB;
        cyc();
        idle();
        check("perr_count", 32'(fifo_count), 32'd1);
        check_head("perr", 2'b10, 9'h020, 32'hAA, 16'd0);
        check("perr_set", 32'(proto_err), 32'd1);
        trace_ready = 1'b1;
        rd      = 1'b1;
        addr    = 9'h033;
        rd_data = 32'h1234;
        cyc();
        idle();
        check_head("load", 2'b01, 9'h033, 32'h1234, 16'd1);
        check("perr_sticky", 32'(proto_err), 32'd1);
        cyc();
        check("load_empty", 32'(trace_valid), 32'd0);

        // Overflow with no drain: five writes into four slots.
        do_reset();
        trace_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_reg(5'(i), 32'(i * 32'h11));
            cyc();
        end
        idle();
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag",  32'(overflow),   32'd1);
        check("ovf_drop",  32'(drop_count), 32'd1);
        trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("drain%0d", i), 2'b00, 9'(i + 1), 32'((i + 1) * 32'h11), 16'(i));
            cyc();
        end
        check("drain_empty", 32'(trace_valid), 32'd0);
        trace_ready = 1'b0;
        set_reg(5'd9, 32'h99);
        cyc();
        idle();
        check("gap_seq", 32'(trace_seq), 32'd5);

        // Dual pushes against limited room: one free slot keeps only the register event.
        set_reg(5'd2, 32'h22);
        set_wr(9'h040, 32'h66);
        cyc();
        check("d2_count", 32'(fifo_count), 32'd3);
        set_reg(5'd3, 32'h33);
        set_wr(9'h041, 32'h77);
        cyc();
        check("d3_count", 32'(fifo_count), 32'd4);
        check("d3_drop",  32'(drop_count), 32'd2);
        cyc();
        idle();
        check("d4_count", 32'(fifo_count), 32'd4);
        check("d4_drop",  32'(drop_count), 32'd4);

        // Full FIFO with a pop in the same cycle still drops the new event.
        trace_ready = 1'b1;
        set_reg(5'd4, 32'h44);
        cyc();
        idle();
        check("fullpop_count", 32'(fifo_count), 32'd3);
        check("fullpop_drop",  32'(drop_count), 32'd5);
        check_head("fp0", 2'b00, 9'h002, 32'h22, 16'd6);
        cyc();
        check_head("fp1", 2'b10, 9'h040, 32'h66, 16'd7);
        cyc();
        check_head("fp2", 2'b00, 9'h003, 32'h33, 16'd8);
        cyc();
        check("fp_empty", 32'(trace_valid), 32'd0);
        trace_ready = 1'b0;
        set_reg(5'd1, 32'h1);
        cyc();
        idle();
        check("fp_seq", 32'(trace_seq), 32'd13);

        // Reset mid-operation discards buffered records and the reset-cycle event.
        do_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_reg(5'd6, 32'(i));
            cyc();
        end
        check("mid_count3", 32'(fifo_count), 32'd3);
        reset = 1'b0;
        set_reg(5'd8, 32'h88);
        cyc();
        idle();
        reset = 1'b1;
        check("mid_count0", 32'(fifo_count),  32'd0);
        check("mid_valid",  32'(trace_valid), 32'd0);
        set_reg(5'd1, 32'hABCD);
        cyc();
        idle();
        check_head("post_rst", 2'b00, 9'h001, 32'hABCD, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/riscv_trace_collector.md
# riscv_trace_collector

Receiving end of the core's debug trace outputs (register-writeback trace and data-memory access trace). Samples both trace channels every cycle and converts them into ordered, sequence-numbered event records. Buffers the records in a FIFO and drains them over a valid/ready stream to a testbench sink or a host-link serializer. Reports drops on overflow instead of stalling the core.

## Interface

**Parameters**
- `DATA_W`, 32: data width of the trace words.
- `DEPTH`, 16: FIFO entries; must be a power of two, at least 2.
- `ADDR_W`, 9: memory trace address width.

**Ports**
- `clk`, in, 1: the block's single clock.
- `reset`, in, 1: synchronous, active-low reset (0 = reset).
- `trace_en`, in, 1: capture enable. When low, no events are captured and `trace_seq` does not advance.
- `reg_write_sig`, in, 1: register writeback strobe.
- `reg_num`, in, 5: destination register.
- `reg_data`, in, DATA_W: writeback value.
- `wr`, in, 1: memory write strobe.
- `rd`, in, 1: memory read strobe.
- `addr`, in, ADDR_W: memory address.
- `wr_data`, in, DATA_W: store data.
- `rd_data`, in, DATA_W: load data.
- `trace_valid`, out, 1: head record available.
- `trace_ready`, in, 1: sink accepts the head record.
- `trace_kind`, out, 2: record type. 00 = register write, 01 = memory read, 10 = memory write.
- `trace_tag`, out, ADDR_W: `reg_num` zero-extended, or `addr`.
- `trace_data`, out, DATA_W: `reg_data`, `rd_data` or `wr_data`.
- `trace_seq`, out, 16: sequence number of the head record.
- `fifo_count`, out, $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`, out, 1: sticky; set on the first dropped event.
- `drop_count`, out, 8: dropped events, saturating at 255.
- `proto_err`, out, 1: sticky; set when `wr` and `rd` are high in the same cycle.

## Operation

**Event detection** (only in cycles with `trace_en`=1)
- Register event: `reg_write_sig`=1 and `reg_num`≠0. Writes to x0 are ignored.
- Memory event:
  - `wr`=1 produces a write record with `wr_data`.
  - `rd`=1 with `wr`=0 produces a read record with `rd_data`.
  - `wr`=`rd`=1 produces a write record only and sets `proto_err`.
- 0, 1 or 2 events per cycle. Push order within a cycle is register event first, then memory event.

**Sequence numbering**
- A 16-bit counter is assigned to each detected event in push order and increments by 1 per detected event, including dropped events, so gaps in `trace_seq` reveal drops.
- The counter wraps from 0xFFFF to 0x0000.

**FIFO**
- Dual-push, single-pop circular buffer. Write and read pointers wrap modulo `DEPTH`.
- Free space is computed from the occupancy at the start of the cycle. A same-cycle pop does not create room for a same-cycle push.
- Two events with exactly one free slot: the register event is stored and the memory event is dropped.
- Any drop sets `overflow` and adds the number of events dropped that cycle (1 or 2) to `drop_count`, saturating at 255.
- Occupancy update: `fifo_count` += pushes − pop.

**Output stream**
- First-word-fall-through: `trace_valid` = (`fifo_count`≠0), and the head record is presented on `trace_kind`, `trace_tag`, `trace_data` and `trace_seq`.
- Pop occurs when `trace_valid` and `trace_ready` are both high.
- Head fields are held stable while `trace_valid`=1 and `trace_ready`=0.
- Head fields are don't-care while `trace_valid`=0.

**Reset** (`reset`=0 at a clock edge)
- Pointers, `fifo_count`, the sequence counter, `overflow`, `drop_count` and `proto_err` are cleared to 0.
- `trace_valid`=0 and `trace_kind`, `trace_tag`, `trace_data`, `trace_seq` all read 0.
- Reset during operation discards all buffered records. Events present in the reset cycle are not captured.

## Timing

- Capture-to-output latency is 1 cycle: an event sampled at edge N appears on `trace_valid`/fields after edge N when the FIFO was empty.
- Sustained throughput is 1 record popped per cycle. Bursts of 2 events per cycle accumulate in the FIFO.
- With `fifo_count`=`DEPTH` and `trace_ready`=1, a pop occurs and any new event in that cycle is still dropped.
- Status outputs (`fifo_count`, `overflow`, `drop_count`, `proto_err`) update on the same edge as the push/pop that changes them.
- No combinational path from any capture input to any output.
- `trace_ready` affects only the pop on the next edge.

## Test plan

1. **Reset:** hold `reset`=0 for 2 cycles with random inputs → `trace_valid`=0, `fifo_count`=0, `drop_count`=0, `overflow`=0, `proto_err`=0, `trace_seq`=0.
2. **Single register write:** `reg_write_sig`=1, `reg_num`=5, `reg_data`=0xDEADBEEF, `trace_ready`=1 → next cycle `trace_valid`=1, `trace_kind`=00, `trace_tag`=0x005, `trace_data`=0xDEADBEEF, `trace_seq`=0; the cycle after, `trace_valid`=0.
3. **Dual event:** in the same cycle, write x3=7 and store to `addr`=0x010 with `wr_data`=0x55 → two records in order: (00, 0x003, 7, seq 0) then (10, 0x010, 0x55, seq 1); `fifo_count` peaks at 2.
4. **Filtering and protocol error:**
   - `reg_num`=0 write → no record and `trace_seq` unchanged.
   - `wr`=`rd`=1 at `addr`=0x020 → single write record and `proto_err`=1, which stays 1.
5. **Overflow** (`DEPTH`=4, `trace_ready`=0): 5 register writes on consecutive cycles → `fifo_count`=4, `overflow`=1, `drop_count`=1. Draining yields seqs 0..3; the next event carries seq 5.
6. **Reset mid-operation:** with `fifo_count`=3 and `trace_ready`=0, pulse `reset`=0 for one cycle → `fifo_count`=0 and `trace_valid`=0. The next captured event is seq 0.
